// File: rtl/mdu_issue_ctrl_if.sv
// Issue-controller signal bundle between the E stage, the MDU and the hazard unit.
// The master drives the stage/MDU inputs, and the slave is the controller.
interface mdu_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             req;
    logic [3:0]       d_md_op;
    logic [3:0]       e_md_op;
    logic             e_valid;
    logic             mdu_busy;
    logic             start_E;
    logic [3:0]       mdu_op;
    logic             stall_D;
    logic             busy_shadow;
    logic [5:0]       cycles_left;
    logic             mismatch;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output req, d_md_op, e_md_op, e_valid, mdu_busy,
        input  start_E, mdu_op, stall_D, busy_shadow, cycles_left, mismatch, stall_count
    );

    modport slave (
        input  req, d_md_op, e_md_op, e_valid, mdu_busy,
        output start_E, mdu_op, stall_D, busy_shadow, cycles_left, mismatch, stall_count
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller: start/op generation, D-stage hazard stall, and a shadow
// latency countdown that is cross-checked against the MDU's own busy output.
//
// state | meaning
// IDLE  | no MDU operation in flight; a mult/div in E may start
// RUN   | countdown running; cycles_left shows the remaining RUN cycles
// DONE  | hi/lo writeback cycle; the next cycle returns to IDLE
module mdu_issue_ctrl #(
    parameter int MULT_T = 5,
    parameter int DIV_T  = 10,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              reset,
    mdu_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] MULT_LD = 6'(MULT_T);
    localparam logic [5:0] DIV_LD  = 6'(DIV_T);

    state_t           state_q, state_d;
    logic [5:0]       cycles_left_q, cycles_left_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic e_live;
    logic e_is_muldiv;
    logic e_is_mult;
    logic d_is_md;
    logic start;
    logic busy_shadow;
    logic stall;

    always_comb begin
        e_live      = bus.e_valid && !bus.req;
        e_is_muldiv = (bus.e_md_op >= 4'd1) && (bus.e_md_op <= 4'd4);
        e_is_mult   = (bus.e_md_op == 4'd1) || (bus.e_md_op == 4'd2);
        d_is_md     = (bus.d_md_op >= 4'd1) && (bus.d_md_op <= 4'd8);
        start       = e_live && e_is_muldiv && (state_q == IDLE);
        busy_shadow = (state_q != IDLE);
        stall       = d_is_md && (busy_shadow || bus.mdu_busy || start);
    end

    always_comb begin
        state_d       = state_q;
        cycles_left_d = cycles_left_q;
        mismatch_d    = mismatch_q | (busy_shadow != bus.mdu_busy);
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        // req freezes the countdown because the MDU itself holds during req.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = RUN;
                    cycles_left_d = e_is_mult ? MULT_LD : DIV_LD;
                end
            end
            RUN: begin
                if (!bus.req) begin
                    if (cycles_left_q <= 6'd1) begin
                        state_d       = DONE;
                        cycles_left_d = 6'd0;
                    end else begin
                        cycles_left_d = cycles_left_q - 6'd1;
                    end
                end
            end
            DONE: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                cycles_left_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cycles_left_q <= 6'd0;
            mismatch_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cycles_left_q <= cycles_left_d;
            mismatch_q    <= mismatch_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.start_E     = start;
    assign bus.mdu_op      = e_live ? bus.e_md_op : 4'd0;
    assign bus.stall_D     = stall;
    assign bus.busy_shadow = busy_shadow;
    assign bus.cycles_left = cycles_left_q;
    assign bus.mismatch    = mismatch_q;
    assign bus.stall_count = stall_count_q;
endmodule
